// File: rtl/seq_pattern_tx_if.sv
// Signal bundle for seq_pattern_tx: transmit request and inputs plus the serial outputs.
// Handshake: start is a request with no ready; it is taken only while busy is low
// (IDLE), and pat_in/use_default/reps are captured in that same cycle.
interface seq_pattern_tx_if;
  logic       start;
  logic       use_default;
  logic [3:0] pat_in;
  logic [3:0] reps;
  logic       tx_out;
  logic       tx_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, use_default, pat_in, reps,
    input  tx_out, tx_valid, busy, done
  );

  modport slave (
    input  start, use_default, pat_in, reps,
    output tx_out, tx_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial 4-bit pattern transmitter: sends a latched pattern MSB first, reps times,
// with GAP_CYCLES idle cycles between repetitions, then pulses done for one cycle.
module seq_pattern_tx #(
  parameter logic [3:0]  PATTERN    = 4'b1101,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_pattern_tx_if.slave       bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t     state, state_d;
  logic [3:0] pat, pat_d;
  logic [3:0] rep_cnt, rep_d;
  logic [1:0] bit_cnt, bit_d;
  logic [3:0] gap_cnt, gap_d;
  logic       tx_out_d, tx_valid_d, busy_d, done_d;

  always_comb begin
    state_d = state;
    pat_d   = pat;
    rep_d   = rep_cnt;
    bit_d   = bit_cnt;
    gap_d   = gap_cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pat_d   = bus.use_default ? PATTERN : bus.pat_in;
          rep_d   = bus.reps;
          bit_d   = 2'd0;
          gap_d   = 4'd0;
          state_d = (bus.reps == 4'd0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (bit_cnt == 2'd3) begin
          bit_d = 2'd0;
          if (rep_cnt != 4'd0) rep_d = rep_cnt - 4'd1;
          if (rep_cnt > 4'd1) state_d = (GAP_CYCLES == 0) ? SEND : GAP;
          else                state_d = DONE;
        end else begin
          bit_d = bit_cnt + 2'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_d   = 4'd0;
          state_d = SEND;
        end else begin
          gap_d = gap_cnt + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they land in registers alongside it.
    tx_valid_d = (state_d == SEND);
    tx_out_d   = (state_d == SEND) ? pat_d[2'd3 - bit_d] : 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pat          <= 4'd0;
      rep_cnt      <= 4'd0;
      bit_cnt      <= 2'd0;
      gap_cnt      <= 4'd0;
      bus.tx_out   <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state        <= state_d;
      pat          <= pat_d;
      rep_cnt      <= rep_d;
      bit_cnt      <= bit_d;
      gap_cnt      <= gap_d;
      bus.tx_out   <= tx_out_d;
      bus.tx_valid <= tx_valid_d;
      bus.busy     <= busy_d;
      bus.done     <= done_d;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (gap 2 and gap 0) share stimulus and are
// compared every cycle against a stream-building reference model.
module tb_seq_pattern_tx;

  typedef logic [3:0] q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       use_default = 1'b0;
  logic [3:0] pat_in = 4'd0;
  logic [3:0] reps = 4'd0;
  logic [1:0] dbg2, dbg0;
  int         checks = 0;
  int         errors = 0;

  seq_pattern_tx_if if2 ();
  seq_pattern_tx_if if0 ();

  assign if2.start = start;       assign if0.start = start;
  assign if2.use_default = use_default; assign if0.use_default = use_default;
  assign if2.pat_in = pat_in;     assign if0.pat_in = pat_in;
  assign if2.reps = reps;         assign if0.reps = reps;

  seq_pattern_tx dut_g2 (.clk(clk), .rst(rst), .bus(if2), .dbg_state(dbg2));
  seq_pattern_tx #(.PATTERN(4'b1101), .GAP_CYCLES(0)) dut_g0 (.clk(clk), .rst(rst), .bus(if0), .dbg_state(dbg0));

  always #5 clk = ~clk;

  // Observed outputs packed as {tx_out, tx_valid, busy, done}
  logic [3:0] obs2, obs0;
  assign obs2 = {if2.tx_out, if2.tx_valid, if2.busy, if2.done};
  assign obs0 = {if0.tx_out, if0.tx_valid, if0.busy, if0.done};

  // Reference model: on acceptance, expand the whole transfer into a per-cycle output stream.
  logic [3:0] exp_q2[$];
  logic [3:0] exp_q0[$];
  logic [3:0] exp2 = 4'd0, exp0 = 4'd0;

  function automatic q_t build(logic [3:0] p, int r, int g);
    q_t q;
    q = {};
    for (int i = 0; i < r; i++) begin
      for (int b = 3; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
      if (i < r - 1) for (int k = 0; k < g; k++) q.push_back(4'b0010);
    end
    q.push_back(4'b0011);
    return q;
  endfunction

  always @(posedge clk) begin
    logic [3:0] sel;
    sel = use_default ? 4'b1101 : pat_in;
    if (!rst) begin
      exp_q2.delete();
      exp_q0.delete();
    end else begin
      if (exp_q2.size() == 0) begin
        if (start) exp_q2 = build(sel, int'(reps), 2);
      end else void'(exp_q2.pop_front());
      if (exp_q0.size() == 0) begin
        if (start) exp_q0 = build(sel, int'(reps), 0);
      end else void'(exp_q0.pop_front());
    end
    exp2 = (exp_q2.size() != 0) ? exp_q2[0] : 4'd0;
    exp0 = (exp_q0.size() != 0) ? exp_q0[0] : 4'd0;
  end

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    reps = 4'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks += 3;
      if (obs2 !== 4'd0) begin errors++; $display("FAIL reset g2 cyc %0d: got %b expected 0000", c, obs2); end
      if (obs0 !== 4'd0) begin errors++; $display("FAIL reset g0 cyc %0d: got %b expected 0000", c, obs0); end
      if (dbg2 !== 2'd0) begin errors++; $display("FAIL reset_state g2 cyc %0d: got %0d expected 0", c, dbg2); end
    end
    start = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks += 2;
      if (obs2 !== 4'd0) begin errors++; $display("FAIL reset_release g2 cyc %0d: got %b expected 0000", c, obs2); end
      if (obs0 !== 4'd0) begin errors++; $display("FAIL reset_release g0 cyc %0d: got %b expected 0000", c, obs0); end
    end
  endtask

  task automatic test_default_single();
    logic [4:0] w_tx = 5'b11010;
    logic [4:0] w_v  = 5'b11110;
    logic [4:0] w_d  = 5'b00001;
    use_default = 1'b1;
    pat_in = 4'b0000;
    reps = 4'd1;
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL default_single g2 cyc %0d: got %b expected %b", c + 1, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL default_single g0 cyc %0d: got %b expected %b", c + 1, obs0, exp0); end
      if (c < 5) begin
        checks++;
        if ({if2.tx_out, if2.tx_valid, if2.done} !== {w_tx[4-c], w_v[4-c], w_d[4-c]}) begin
          errors++;
          $display("FAIL default_single_const cyc %0d: got %b expected %b", c + 1,
                   {if2.tx_out, if2.tx_valid, if2.done}, {w_tx[4-c], w_v[4-c], w_d[4-c]});
        end
      end
    end
  endtask

  task automatic test_user_two_reps();
    logic [10:0] w_tx = 11'b10010010010;
    logic [10:0] w_v  = 11'b11110011110;
    logic [10:0] w_d  = 11'b00000000001;
    use_default = 1'b0;
    pat_in = 4'b1001;
    reps = 4'd2;
    start = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      pat_in = 4'b0110;
      reps = 4'd7;
      use_default = 1'b1;
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL user_two_reps g2 cyc %0d: got %b expected %b", c + 1, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL user_two_reps g0 cyc %0d: got %b expected %b", c + 1, obs0, exp0); end
      if (c < 11) begin
        checks++;
        if ({if2.tx_out, if2.tx_valid, if2.done} !== {w_tx[10-c], w_v[10-c], w_d[10-c]}) begin
          errors++;
          $display("FAIL user_two_reps_const cyc %0d: got %b expected %b", c + 1,
                   {if2.tx_out, if2.tx_valid, if2.done}, {w_tx[10-c], w_v[10-c], w_d[10-c]});
        end
      end
    end
  endtask

  task automatic test_zero_reps();
    int busy_cycles = 0;
    int valid_cycles = 0;
    reps = 4'd0;
    start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      busy_cycles += int'(if2.busy);
      valid_cycles += int'(if2.tx_valid);
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL zero_reps g2 cyc %0d: got %b expected %b", c + 1, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL zero_reps g0 cyc %0d: got %b expected %b", c + 1, obs0, exp0); end
      if (c == 0) begin
        checks++;
        if (obs2 !== 4'b0011) begin errors++; $display("FAIL zero_reps_done: got %b expected 0011", obs2); end
      end
    end
    checks += 2;
    if (busy_cycles !== 1) begin errors++; $display("FAIL zero_reps_busy: got %0d cycles expected 1", busy_cycles); end
    if (valid_cycles !== 0) begin errors++; $display("FAIL zero_reps_valid: got %0d cycles expected 0", valid_cycles); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] shreg = 4'd0;
    int hits = 0;
    int nbits = 0;
    logic [11:0] stream = 12'd0;
    use_default = 1'b1;
    reps = 4'd3;
    start = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (if0.tx_valid) begin
        shreg = {shreg[2:0], if0.tx_out};
        if (nbits < 12) stream = {stream[10:0], if0.tx_out};
        nbits++;
        if (nbits >= 4 && shreg == 4'b1101) hits++;
      end
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL back_to_back g2 cyc %0d: got %b expected %b", c + 1, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL back_to_back g0 cyc %0d: got %b expected %b", c + 1, obs0, exp0); end
      if (c == 12) begin
        checks++;
        if (if0.done !== 1'b1) begin errors++; $display("FAIL back_to_back_done: got %b expected 1", if0.done); end
      end
    end
    checks += 3;
    if (nbits !== 12) begin errors++; $display("FAIL back_to_back_bits: got %0d expected 12", nbits); end
    if (stream !== 12'b110111011101) begin errors++; $display("FAIL back_to_back_stream: got %b expected 110111011101", stream); end
    if (hits !== 3) begin errors++; $display("FAIL back_to_back_detect: got %0d expected 3", hits); end
    // Let the gap-2 instance finish its longer transfer.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obs2 !== exp2) begin errors++; $display("FAIL back_to_back_drain g2 cyc %0d: got %b expected %b", c, obs2, exp2); end
    end
  endtask

  task automatic test_reset_mid_send();
    int valid_cnt = 0;
    int done_cnt = 0;
    use_default = 1'b1;
    reps = 4'd2;
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (c == 1) ? 1'b0 : 1'b1;
      done_cnt += int'(if2.done);
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL reset_mid_send g2 cyc %0d: got %b expected %b", c + 1, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL reset_mid_send g0 cyc %0d: got %b expected %b", c + 1, obs0, exp0); end
      if (c == 2) begin
        checks++;
        if (obs2 !== 4'd0) begin errors++; $display("FAIL reset_mid_send_abort: got %b expected 0000", obs2); end
      end
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL reset_mid_send_nodone: got %0d expected 0", done_cnt); end
    done_cnt = 0;
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      valid_cnt += int'(if2.tx_valid);
      done_cnt += int'(if2.done);
      checks++;
      if (obs2 !== exp2) begin errors++; $display("FAIL reset_fresh g2 cyc %0d: got %b expected %b", c + 1, obs2, exp2); end
    end
    checks += 2;
    if (valid_cnt !== 8) begin errors++; $display("FAIL reset_fresh_bits: got %0d expected 8", valid_cnt); end
    if (done_cnt !== 1) begin errors++; $display("FAIL reset_fresh_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_ignored_start();
    logic [10:0] w_tx = 11'b10010010010;
    use_default = 1'b0;
    pat_in = 4'b1001;
    reps = 4'd2;
    start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      // Pulses land in SEND (cyc 2), GAP (cyc 5) and DONE (cyc 11) of the gap-2 instance.
      start = (c == 1 || c == 4 || c == 10);
      pat_in = 4'($urandom_range(0, 15));
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL ignored_start g2 cyc %0d: got %b expected %b", c + 1, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL ignored_start g0 cyc %0d: got %b expected %b", c + 1, obs0, exp0); end
      if (c < 11) begin
        checks++;
        if (if2.tx_out !== w_tx[10-c]) begin errors++; $display("FAIL ignored_start_bit cyc %0d: got %b expected %b", c + 1, if2.tx_out, w_tx[10-c]); end
      end
      if (c == 11) begin
        checks++;
        if (if2.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_idle: got %b expected 0", if2.busy); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL random g2 cyc %0d: got %b expected %b", c, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL random g0 cyc %0d: got %b expected %b", c, obs0, exp0); end
      start = ($urandom_range(0, 3) == 0);
      use_default = 1'($urandom_range(0, 1));
      pat_in = 4'($urandom_range(0, 15));
      reps = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) != 0);
    end
    start = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks += 2;
      if (obs2 !== exp2) begin errors++; $display("FAIL random_drain g2 cyc %0d: got %b expected %b", c, obs2, exp2); end
      if (obs0 !== exp0) begin errors++; $display("FAIL random_drain g0 cyc %0d: got %b expected %b", c, obs0, exp0); end
    end
  endtask

  initial begin
    test_reset();
    test_default_single();
    test_user_two_reps();
    test_zero_reps();
    test_back_to_back();
    test_reset_mid_send();
    test_ignored_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PATTERN, default 4'b1101, SHALL be the built-in pattern sent when use_default is high.
REQ-002 Parameter GAP_CYCLES, default 2, range 0-15, SHALL be the number of idle cycles inserted between repetitions.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start  input  1  SHALL be the transmit request, sampled only in IDLE.
REQ-006 use_default  input  1  SHALL select PATTERN (1) or pat_in (0), sampled with start.
REQ-007 pat_in  input  4  SHALL be the user pattern, MSB sent first.
REQ-008 reps  input  4  SHALL be the repetition count, 0-15, sampled with start.
REQ-009 tx_out  output  1  SHALL be the registered serial data bit.
REQ-010 tx_valid  output  1  SHALL be high on cycles where tx_out carries a pattern bit.
REQ-011 busy  output  1  SHALL be high in states SEND, GAP and DONE.
REQ-012 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SEND, GAP, DONE.
REQ-014 All outputs SHALL be registered and SHALL be Moore outputs decoded from the current state and counters.
REQ-015 In IDLE, tx_out, tx_valid, busy and done SHALL all be 0.
REQ-016 Start acceptance: start=1 in IDLE at edge N SHALL latch the pattern (per use_default) and reps.
- reps≠0: the FSM SHALL enter SEND at edge N.
- reps=0: the FSM SHALL enter DONE at edge N and send no bits.
REQ-017 SEND SHALL last 4 cycles, driving tx_valid=1 and tx_out = latched bit 3, 2, 1, 0 in that order.
- The first bit SHALL be visible in the cycle after edge N.
REQ-018 After the 4th bit, the remaining-repetition counter SHALL decrement by 1.
REQ-019 If repetitions remain and GAP_CYCLES>0, the FSM SHALL enter GAP for exactly GAP_CYCLES cycles with tx_out=0 and tx_valid=0, then return to SEND.
REQ-020 If repetitions remain and GAP_CYCLES=0, SEND SHALL restart back-to-back with no dead cycle.
REQ-021 If no repetitions remain, the FSM SHALL enter DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, busy=1, tx_valid=0 and tx_out=0, then SHALL return to IDLE.
REQ-023 Latency: cycles from the edge that accepts start to the done cycle, inclusive, SHALL be reps*4 + (reps-1)*GAP_CYCLES + 1 for reps≥1, and 1 for reps=0.
REQ-024 start asserted outside IDLE, including in DONE, SHALL be ignored with no effect on latched values.
REQ-025 A start held high continuously SHALL begin a new transfer in the first IDLE cycle after DONE.
REQ-026 Changes to pat_in, use_default or reps after acceptance SHALL NOT affect the transfer in progress.
REQ-027 The bit counter (2 bits) SHALL wrap 3→0 only at a SEND boundary.
REQ-028 The repetition counter SHALL never underflow.
REQ-029 The gap counter SHALL count from 0 to GAP_CYCLES-1.

Reset
REQ-030 rst=0 at any rising edge SHALL force state IDLE, clear all counters and latched registers, and drive tx_out=0, tx_valid=0, busy=0, done=0 from the following cycle.
REQ-031 Reset asserted mid-SEND or mid-GAP SHALL abort the transfer with no done pulse.
REQ-032 start sampled during reset SHALL be ignored.
REQ-033 Outputs SHALL power up at 0.

Verification
REQ-034 use_default=1, reps=1, GAP=2, pulse start -> tx_out 1,1,0,1 with tx_valid=1 on 4 cycles, then done=1 on the 5th cycle.
REQ-035 pat_in=4'b1001, use_default=0, reps=2, GAP=2 -> tx_out 1,0,0,1,0,0,1,0,0,1 with tx_valid 1,1,1,1,0,0,1,1,1,1; done on cycle 11.
REQ-036 reps=0, start -> done=1 on the next cycle, tx_valid never asserted, busy high for that one cycle only.
REQ-037 reps=3, GAP=0, PATTERN=1101 -> 12 consecutive valid bits 110111011101, then done; a serial 1101 detector fed tx_out SHALL flag three times (overlap included).
REQ-038 rst=0 on the 2nd SEND cycle of reps=2 -> all outputs 0 next cycle, no done; a subsequent start transmits a full fresh sequence.
REQ-039 start pulses during SEND, during GAP and during DONE -> no change to the bit stream or the done timing.
